// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store stage: memory-op encodings, FSM states
// and the small decode helpers used by both the FSM and the lane aligner.
package lsu_pkg;

  localparam int MEM_OP_W = 4;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB   = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH   = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD
  } lsu_state_e;

  // Unused encodings fall through to the plain writeback path.
  function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op,
                                         input logic [1:0] off);
    logic half_op;
    logic word_op;
    half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
    word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
    return (half_op && off[0]) || (word_op && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus bundle between the load/store stage (master) and memory (slave).
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  dbus_req;
  logic                  dbus_we;
  logic [ADDR_WIDTH-1:0] dbus_addr;
  logic [3:0]            dbus_be;
  logic [DATA_WIDTH-1:0] dbus_wdata;
  logic                  dbus_gnt;
  logic                  dbus_rvalid;
  logic [DATA_WIDTH-1:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_gnt, dbus_rvalid, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_gnt, dbus_rvalid, dbus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data on the way
// out, byte/half extraction with sign or zero extension on the way back.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [MEM_OP_W-1:0]   st_op,
  input  logic [1:0]            st_off,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [MEM_OP_W-1:0]   ld_op,
  input  logic [1:0]            ld_off,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ld_data
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int HALVES = DATA_WIDTH / 16;

  logic [DATA_WIDTH-1:0] shifted;

  // Loads carry size-based enables too so the memory sees a consistent access.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (st_op)
      MEM_OP_SB, MEM_OP_LB, MEM_OP_LBU: be = 4'b0001 << st_off;
      MEM_OP_SH, MEM_OP_LH, MEM_OP_LHU: be = 4'b0011 << st_off;
      default: be = 4'b1111;
    endcase
    case (st_op)
      MEM_OP_SB: wdata = {BYTES{store_data[7:0]}};
      MEM_OP_SH: wdata = {HALVES{store_data[15:0]}};
      default:   wdata = store_data;
    endcase
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = rdata;
    case (ld_op)
      MEM_OP_LB:  ld_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      MEM_OP_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      MEM_OP_LH:  ld_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      MEM_OP_LHU: ld_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default:    ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store + writeback register stage behind the ALU. One bus request in
// flight at a time; EX is stalled through ex_ready until the access finishes.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [MEM_OP_W-1:0]   mem_op,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [4:0]            rd_addr,
  input  logic                  flush,
  lsu_if.master                 dbus,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign_exc,
  output logic [ADDR_WIDTH-1:0] exc_addr
);

  lsu_state_e state, state_next;

  logic [MEM_OP_W-1:0]   op_q;
  logic [1:0]            off_q;
  logic [4:0]            rd_q;
  logic                  kill_q;
  logic                  accept;
  logic                  wb_fire;
  logic                  exc_fire;
  logic                  latch_req;
  logic                  kill_set;
  logic [DATA_WIDTH-1:0] wb_data_d;
  logic [4:0]            wb_rd_d;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] ld_data_c;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_op      (mem_op),
    .st_off     (alu_out[1:0]),
    .store_data (store_data),
    .be         (be_c),
    .wdata      (wdata_c),
    .ld_op      (op_q),
    .ld_off     (off_q),
    .rdata      (dbus.dbus_rdata),
    .ld_data    (ld_data_c)
  );

  assign ex_ready = (state == S_IDLE);
  assign accept   = ex_valid && ex_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // kill_q remembers a flush that arrived after the bus already took the load.
  always_comb begin
    state_next = state;
    wb_fire    = 1'b0;
    exc_fire   = 1'b0;
    latch_req  = 1'b0;
    kill_set   = 1'b0;
    wb_data_d  = wb_data;
    wb_rd_d    = wb_rd_addr;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem_op(mem_op)) begin
            wb_fire   = 1'b1;
            wb_data_d = alu_out;
            wb_rd_d   = rd_addr;
          end else if (is_misaligned(mem_op, alu_out[1:0])) begin
            exc_fire = 1'b1;
          end else begin
            latch_req  = 1'b1;
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dbus.dbus_gnt) begin
          if (is_store(op_q)) begin
            state_next = S_IDLE;
          end else if (dbus.dbus_rvalid) begin
            state_next = S_IDLE;
            wb_fire    = !flush;
            wb_data_d  = ld_data_c;
            wb_rd_d    = rd_q;
          end else begin
            state_next = S_WAIT_RD;
            kill_set   = flush;
          end
        end else if (flush) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (dbus.dbus_rvalid) begin
          state_next = S_IDLE;
          wb_fire    = !flush && !kill_q;
          wb_data_d  = ld_data_c;
          wb_rd_d    = rd_q;
        end else begin
          kill_set = flush;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q            <= MEM_OP_NONE;
      off_q           <= 2'b00;
      rd_q            <= 5'd0;
      kill_q          <= 1'b0;
      dbus.dbus_req   <= 1'b0;
      dbus.dbus_we    <= 1'b0;
      dbus.dbus_addr  <= '0;
      dbus.dbus_be    <= 4'b0000;
      dbus.dbus_wdata <= '0;
      wb_valid        <= 1'b0;
      wb_rd_addr      <= 5'd0;
      wb_data         <= '0;
      misalign_exc    <= 1'b0;
      exc_addr        <= '0;
    end else begin
      dbus.dbus_req <= (state_next == S_REQ);
      wb_valid      <= wb_fire;
      misalign_exc  <= exc_fire;
      wb_data       <= wb_data_d;
      wb_rd_addr    <= wb_rd_d;
      if (exc_fire) exc_addr <= alu_out[ADDR_WIDTH-1:0];
      if (latch_req) begin
        op_q            <= mem_op;
        off_q           <= alu_out[1:0];
        rd_q            <= rd_addr;
        kill_q          <= 1'b0;
        dbus.dbus_we    <= is_store(mem_op);
        dbus.dbus_addr  <= {alu_out[ADDR_WIDTH-1:2], 2'b00};
        dbus.dbus_be    <= be_c;
        dbus.dbus_wdata <= wdata_c;
      end else if (kill_set) begin
        kill_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: pass-through writeback, stores, loads
// with extension, misalignment traps, flushes and reset during a pending read.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [3:0]  mem_op = MEM_OP_NONE;
  logic [31:0] alu_out = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        misalign_exc;
  logic [31:0] exc_addr;

  int testsRun = 0;
  int testsFailed = 0;

  lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .mem_op       (mem_op),
    .alu_out      (alu_out),
    .store_data   (store_data),
    .rd_addr      (rd_addr),
    .flush        (flush),
    .dbus         (bus),
    .wb_valid     (wb_valid),
    .wb_rd_addr   (wb_rd_addr),
    .wb_data      (wb_data),
    .misalign_exc (misalign_exc),
    .exc_addr     (exc_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [4:0] rd, input logic fl);
    ex_valid   = v;
    mem_op     = op;
    alu_out    = a;
    store_data = sd;
    rd_addr    = rd;
    flush      = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // waitCycles = number of cycles between gnt and rvalid (0 = same cycle).
  task automatic loadOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input int waitCycles, input logic [31:0] expected);
    applyStimulus(1'b1, op, a, 32'h0, rd, 1'b0);
    tick();
    idle();
    checkOutput({tag, " req"}, bus.dbus_req, 1);
    checkOutput({tag, " addr"}, bus.dbus_addr, a & 32'hFFFF_FFFC);
    bus.dbus_gnt = 1'b1;
    if (waitCycles == 0) begin
      bus.dbus_rvalid = 1'b1;
      bus.dbus_rdata  = rdata;
    end
    tick();
    bus.dbus_gnt = 1'b0;
    if (waitCycles > 0) begin
      repeat (waitCycles - 1) tick();
      checkOutput({tag, " stall"}, ex_ready, 0);
      checkOutput({tag, " no early wb"}, wb_valid, 0);
      bus.dbus_rvalid = 1'b1;
      bus.dbus_rdata  = rdata;
      tick();
    end
    bus.dbus_rvalid = 1'b0;
    bus.dbus_rdata  = 32'h0;
    checkOutput({tag, " wb_valid"}, wb_valid, 1);
    checkOutput({tag, " wb_data"}, wb_data, expected);
    checkOutput({tag, " wb_rd"}, wb_rd_addr, rd);
    checkOutput({tag, " ready"}, ex_ready, 1);
    tick();
    checkOutput({tag, " wb pulse"}, wb_valid, 0);
  endtask

  initial begin
    bus.dbus_gnt    = 1'b0;
    bus.dbus_rvalid = 1'b0;
    bus.dbus_rdata  = 32'h0;
    idle();

    repeat (2) tick();
    checkOutput("reset ex_ready", ex_ready, 1);
    checkOutput("reset req", bus.dbus_req, 0);
    checkOutput("reset we", bus.dbus_we, 0);
    checkOutput("reset be", bus.dbus_be, 0);
    checkOutput("reset addr", bus.dbus_addr, 0);
    checkOutput("reset wb_valid", wb_valid, 0);
    checkOutput("reset wb_data", wb_data, 0);
    checkOutput("reset misalign", misalign_exc, 0);
    rst_n = 1'b1;
    tick();

    // Plain pass-through writeback
    applyStimulus(1'b1, MEM_OP_NONE, 32'h1234_5678, 32'h0, 5'd5, 1'b0);
    tick();
    idle();
    checkOutput("none wb_valid", wb_valid, 1);
    checkOutput("none wb_data", wb_data, 32'h1234_5678);
    checkOutput("none wb_rd", wb_rd_addr, 5);
    checkOutput("none ready", ex_ready, 1);
    tick();
    checkOutput("none pulse", wb_valid, 0);

    // SB to 0x1003, grant after two wait cycles
    applyStimulus(1'b1, MEM_OP_SB, 32'h0000_1003, 32'h0000_00AB, 5'd0, 1'b0);
    tick();
    idle();
    checkOutput("sb req c1", bus.dbus_req, 1);
    checkOutput("sb addr", bus.dbus_addr, 32'h0000_1000);
    checkOutput("sb be", bus.dbus_be, 4'b1000);
    checkOutput("sb wdata", bus.dbus_wdata, 32'hABAB_ABAB);
    checkOutput("sb we", bus.dbus_we, 1);
    checkOutput("sb stall", ex_ready, 0);
    tick();
    checkOutput("sb req c2", bus.dbus_req, 1);
    tick();
    checkOutput("sb req c3", bus.dbus_req, 1);
    checkOutput("sb addr stable", bus.dbus_addr, 32'h0000_1000);
    bus.dbus_gnt = 1'b1;
    tick();
    bus.dbus_gnt = 1'b0;
    checkOutput("sb req dropped", bus.dbus_req, 0);
    checkOutput("sb ready", ex_ready, 1);
    checkOutput("sb no wb", wb_valid, 0);

    // SH to 0x1002 with immediate grant
    applyStimulus(1'b1, MEM_OP_SH, 32'h0000_1002, 32'h1234_BEEF, 5'd0, 1'b0);
    tick();
    idle();
    checkOutput("sh be", bus.dbus_be, 4'b1100);
    checkOutput("sh wdata", bus.dbus_wdata, 32'hBEEF_BEEF);
    bus.dbus_gnt = 1'b1;
    tick();
    bus.dbus_gnt = 1'b0;
    checkOutput("sh req dropped", bus.dbus_req, 0);
    checkOutput("sh no wb", wb_valid, 0);

    // Loads: extension, lane select, wait and same-cycle rvalid
    loadOp("lb", MEM_OP_LB, 32'h0000_2002, 32'h0080_0000, 5'd9, 3, 32'hFFFF_FF80);
    loadOp("lbu", MEM_OP_LBU, 32'h0000_2002, 32'h0080_0000, 5'd10, 0, 32'h0000_0080);
    loadOp("lhu", MEM_OP_LHU, 32'h0000_2002, 32'h0080_0000, 5'd11, 1, 32'h0000_0080);
    loadOp("lh", MEM_OP_LH, 32'h0000_2000, 32'h1234_8001, 5'd12, 0, 32'hFFFF_8001);
    loadOp("lw", MEM_OP_LW, 32'h0000_2004, 32'hDEAD_BEEF, 5'd13, 2, 32'hDEAD_BEEF);
    loadOp("lb pos", MEM_OP_LB, 32'h0000_2001, 32'h0000_7F00, 5'd14, 0, 32'h0000_007F);

    // Misaligned LW and SH trap with no bus access
    applyStimulus(1'b1, MEM_OP_LW, 32'h0000_2002, 32'h0, 5'd3, 1'b0);
    tick();
    idle();
    checkOutput("lw misalign exc", misalign_exc, 1);
    checkOutput("lw misalign addr", exc_addr, 32'h0000_2002);
    checkOutput("lw misalign no req", bus.dbus_req, 0);
    checkOutput("lw misalign no wb", wb_valid, 0);
    checkOutput("lw misalign ready", ex_ready, 1);
    tick();
    checkOutput("misalign pulse", misalign_exc, 0);
    applyStimulus(1'b1, MEM_OP_SH, 32'h0000_1001, 32'h0, 5'd0, 1'b0);
    tick();
    idle();
    checkOutput("sh misalign exc", misalign_exc, 1);
    checkOutput("sh misalign addr", exc_addr, 32'h0000_1001);
    checkOutput("sh misalign no req", bus.dbus_req, 0);
    tick();

    // Flush in IDLE blocks the accept
    applyStimulus(1'b1, MEM_OP_NONE, 32'h0000_0055, 32'h0, 5'd4, 1'b1);
    tick();
    idle();
    checkOutput("idle flush no wb", wb_valid, 0);

    // Flush in REQ without grant drops the request
    applyStimulus(1'b1, MEM_OP_LW, 32'h0000_3000, 32'h0, 5'd6, 1'b0);
    tick();
    idle();
    checkOutput("req flush req up", bus.dbus_req, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("req flush req drop", bus.dbus_req, 0);
    checkOutput("req flush ready", ex_ready, 1);
    tick();
    checkOutput("req flush no wb", wb_valid, 0);

    // Flush in WAIT_RD: read completes, writeback suppressed
    applyStimulus(1'b1, MEM_OP_LW, 32'h0000_3004, 32'h0, 5'd6, 1'b0);
    tick();
    idle();
    bus.dbus_gnt = 1'b1;
    tick();
    bus.dbus_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("wait flush stall", ex_ready, 0);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h1111_1111;
    tick();
    bus.dbus_rvalid = 1'b0;
    checkOutput("wait flush no wb", wb_valid, 0);
    checkOutput("wait flush ready", ex_ready, 1);

    // Reset during WAIT_RD, later rvalid ignored
    applyStimulus(1'b1, MEM_OP_LW, 32'h0000_4000, 32'h0, 5'd8, 1'b0);
    tick();
    idle();
    bus.dbus_gnt = 1'b1;
    tick();
    bus.dbus_gnt = 1'b0;
    checkOutput("rst wait stall", ex_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst async req", bus.dbus_req, 0);
    checkOutput("rst async wb", wb_valid, 0);
    checkOutput("rst async ready", ex_ready, 1);
    #2;
    rst_n = 1'b1;
    tick();
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 32'h2222_2222;
    tick();
    bus.dbus_rvalid = 1'b0;
    checkOutput("rst stale rvalid", wb_valid, 0);
    applyStimulus(1'b1, MEM_OP_NONE, 32'hCAFE_F00D, 32'h0, 5'd7, 1'b0);
    tick();
    idle();
    checkOutput("post rst wb_valid", wb_valid, 1);
    checkOutput("post rst wb_data", wb_data, 32'hCAFE_F00D);
    checkOutput("post rst wb_rd", wb_rd_addr, 7);

    // Back-to-back accepts, rd=0 still writes back
    applyStimulus(1'b1, MEM_OP_NONE, 32'hA5A5_0001, 32'h0, 5'd0, 1'b0);
    tick();
    checkOutput("b2b first valid", wb_valid, 1);
    checkOutput("b2b first rd0", wb_rd_addr, 0);
    applyStimulus(1'b1, MEM_OP_NONE, 32'h5A5A_0002, 32'h0, 5'd31, 1'b0);
    tick();
    idle();
    checkOutput("b2b second valid", wb_valid, 1);
    checkOutput("b2b second data", wb_data, 32'h5A5A_0002);
    checkOutput("b2b second rd", wb_rd_addr, 31);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store and writeback-register stage directly downstream of `alu`. Takes the ALU result (`alu_out`) for each EX-stage instruction:

- **Memory ops:** the result is used as the effective address for a data-bus transaction. Byte lanes are aligned, load data is sign/zero-extended, and misaligned accesses are trapped.
- **All other ops:** the result is registered through unchanged to writeback.

A one-request-in-flight FSM stalls EX via `ex_ready` while a bus access is outstanding.

## Interface

Parameters:
- `DATA_WIDTH`, 32, GPR/data-bus width (equals `DATA_WIDTH_GPR`).
- `ADDR_WIDTH`, 32, data-bus address width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  EX presents an instruction.
- `ex_ready`  out  1  stage can accept; transfer when `ex_valid & ex_ready`.
- `mem_op`  in  4  `MEM_OP_*`: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
- `alu_out`  in  DATA_WIDTH  ALU result; effective address for mem ops.
- `store_data`  in  DATA_WIDTH  rs2 value for stores.
- `rd_addr`  in  5  destination register.
- `flush`  in  1  discard the current operation (branch/exception redirect).
- `dbus_req`  out  1  bus request, held until `dbus_gnt`.
- `dbus_we`  out  1  1 = store.
- `dbus_addr`  out  ADDR_WIDTH  word-aligned address (`[1:0]` = 0).
- `dbus_be`  out  4  byte enables.
- `dbus_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `dbus_gnt`  in  1  request accepted this cycle.
- `dbus_rvalid`  in  1  read data valid.
- `dbus_rdata`  in  DATA_WIDTH  read data.
- `wb_valid`  out  1  one-cycle writeback pulse.
- `wb_rd_addr`  out  5  writeback register.
- `wb_data`  out  DATA_WIDTH  writeback value.
- `misalign_exc`  out  1  one-cycle misaligned-access pulse.
- `exc_addr`  out  ADDR_WIDTH  faulting effective address.

## Operation

- FSM states: IDLE, REQ, WAIT_RD.
- `ex_ready` = (state == IDLE). `ex_ready` and `flush` are independent.
- **Accept in IDLE:**
  - `mem_op` NONE: latch `alu_out`/`rd_addr`; `wb_valid` next cycle; stay IDLE.
  - Misaligned (LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0): no bus access; `misalign_exc`=1 and `exc_addr`=`alu_out` next cycle; no writeback; stay IDLE.
  - Otherwise: latch op, address, data, rd; go to REQ.
- **REQ:** `dbus_req`=1 with all bus outputs stable.
  - On `dbus_gnt`, a store goes to IDLE with no writeback.
  - On `dbus_gnt`, a load goes to WAIT_RD. If `dbus_rvalid` arrives in the same cycle, the load completes directly and returns to IDLE.
- **WAIT_RD:** on `dbus_rvalid`, register the extracted/extended data; `wb_valid` next cycle; go to IDLE.
- **Byte enables:** SB `4'b0001 << addr[1:0]`; SH `4'b0011 << addr[1:0]`; SW `4'b1111`.
- **Store data:** SB replicates byte ×4; SH replicates half ×2; SW as-is.
- **Load extract:** byte = `rdata >> (8*addr[1:0])`, half = `rdata >> (8*addr[1:0])`, then LB/LH sign-extend and LBU/LHU zero-extend.
- **Flush:**
  - In IDLE: blocks the accept that cycle.
  - In REQ without gnt: drop `dbus_req`, go to IDLE.
  - In REQ with gnt, or in WAIT_RD: the granted transaction completes, but writeback is suppressed.
- `dbus_rvalid` and `dbus_gnt` are ignored in IDLE.
- `rd_addr` = 0 still produces `wb_valid`; the register file drops the write.

## Timing

- **Reset values:** state IDLE; `ex_ready`=1; `dbus_req`=0, `dbus_we`=0, `dbus_be`=0; `wb_valid`=0, `misalign_exc`=0. Addresses and data are 0.
- **Reset mid-operation:** bus request drops asynchronously; any in-flight load result is discarded.
- **Latencies (accept at cycle N):**
  - NONE: `wb_valid` at N+1.
  - Misaligned: `misalign_exc` at N+1.
  - Store: `dbus_req` from N+1; `ex_ready` from the cycle after gnt.
  - Load with gnt at G, rvalid at R≥G: `wb_valid` at R+1; `ex_ready` at R+1.
- Back-to-back: a new accept is possible in the same cycle the previous `wb_valid` is high.
- All outputs are registered; there is no combinational path from `dbus_*` inputs to `dbus_req`.

## Structure

- `MEM_OP_*` encodings and the `MEM_OP` width go in `define.v` beside `ALU_OP_*`, shared with the decoder.
- Sub-module `lsu_align`: combinational byte-enable/wdata generation plus load extract/extend, instantiated once.
- The FSM and registers live in `lsu`.

## Test plan

- `mem_op`=NONE, `alu_out`=0x1234_5678, rd=5 → N+1: `wb_valid`=1, `wb_data`=0x1234_5678, `wb_rd_addr`=5.
- SB, addr 0x1003, `store_data`=0xAB, gnt after 2 wait cycles → `dbus_addr`=0x1000, `be`=4'b1000, `wdata`=0xABAB_ABAB, req held 3 cycles, no `wb_valid`.
- LB, addr 0x2002, `rdata`=0x0080_0000, rvalid 3 cycles after gnt → `wb_data`=0xFFFF_FF80; LBU gives 0x0000_0080; LHU at 0x2002 gives 0x0000_0080.
- LW at 0x2002 → N+1: `misalign_exc`=1, `exc_addr`=0x2002, no `dbus_req`.
- Flush while in REQ with gnt=0 → `dbus_req` drops next cycle, no writeback. Flush in WAIT_RD → rvalid consumed, no `wb_valid`.
- Assert `rst_n`=0 during WAIT_RD → `dbus_req`/`wb_valid` 0 immediately; after release, a later rvalid is ignored and the next NONE op writes back normally.
